interrupt_scheduler: RTL
========================

// Module: interrupt_scheduler
// PURPOSE
//  Sequences the CPU's halt and quantum-timer interrupts.
//  - Holds pending requests and arbitrates between them.
//  - Forces the PC to the trap vector and saves the interrupted PC.
//  - Provides the cause word that the handler reads back.
//  - Masks further traps until the handler returns.
//  Sits between the control unit (Halt, setClock, getInterruption), the PC
//  next-value mux and the PC-select mux feeding the register bank.
// PARAMETERS
//  PC_WIDTH     11  width of PC / saved PC
//  TIMER_WIDTH  16  quantum counter width (loaded from the immediate field)
//  TRAP_VECTOR  0   PC value forced during a trap
//  CAUSE_TIMER  1   cause code for timer expiry
//  CAUSE_HALT   2   cause code for program halt
// PORTS
//  Clock         in   1            CPU clock; all state updates on posedge
//  Reset_n       in   1            asynchronous active-low reset
//  halt_req      in   1            Halt decoded this cycle
//  timer_set     in   1            setClock: load quantum from timer_value
//  timer_value   in   TIMER_WIDTH  quantum in cycles; 0 disarms the timer
//  pc_next       in   PC_WIDTH     PC value that would load this cycle
//  int_ack       in   1            getInterruption: handler consumed cause
//  int_return    in   1            handler finished; unmask traps
//  trap          out  1            PC mux selects trap_vector this cycle
//  trap_vector   out  PC_WIDTH     constant TRAP_VECTOR
//  saved_pc      out  PC_WIDTH     PC captured at last trap
//  cause         out  32           current cause code, zero-extended; 0 = none
//  in_service    out  1            handler active; traps masked
//  timer_running out  1            quantum counter armed
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - state=IDLE, counter=0, pending flags=0.
//   - trap=0, saved_pc=0, cause=0, in_service=0, timer_running=0.
//   - Reset mid-trap or mid-service abandons it; nothing is retained.
//  Quantum timer:
//   - timer_set & timer_value!=0: counter<=timer_value, running=1.
//   - timer_set & timer_value==0: running=0.
//   - Counter decrements once per cycle while running and state==IDLE;
//     it is frozen in TRAP and SERVICE.
//   - On the cycle the counter goes 1->0: timer_pend<=1, running<=0 (one-shot).
//   - timer_set in the same cycle as expiry: the load wins and no pend is set.
//  Pending:
//   - halt_req sets halt_pend in any state.
//   - A pend flag clears only when its trap is taken.
//  FSM IDLE -> TRAP -> SERVICE -> IDLE:
//   - IDLE: if halt_pend|timer_pend -> TRAP. Priority halt > timer; the loser
//     stays pending. A request registered at edge N traps in cycle N+1
//     (1-cycle latency).
//   - TRAP (exactly 1 cycle): trap=1 combinationally.
//     * saved_pc<=pc_next (the non-trap next PC) at the exit edge.
//     * cause<=winner code; clear the winner's pend.
//     * Next state: SERVICE.
//   - SERVICE: in_service=1, trap=0.
//     * int_ack clears cause to 0 at the next edge; saved_pc is held.
//     * int_return -> IDLE. If a pend exists, TRAP follows on the next cycle.
//     * int_ack and int_return together: both take effect.
//   - halt_req or expiry during TRAP/SERVICE only sets pend; traps never nest.
//  Widths:
//   - cause = {30'b0, code[1:0]}.
//   - saved_pc is exactly PC_WIDTH bits; no wrap logic is needed.
// STRUCTURE
//  - Shared package: state encoding (IDLE/TRAP/SERVICE) and CAUSE_* codes,
//    also used by the control unit and the PC-select mux.
//  - Sub-module quantum_timer: load/disarm/decrement, expire pulse, running flag.
//    Its inputs are count_enable (state==IDLE), load and value.
//  - Pend flags, FSM and saved_pc/cause registers live in the top module.
// TESTING
//  1. Reset_n low mid-SERVICE (cause=2) -> every output 0 at once, before
//     the next Clock edge.
//  2. timer_set=1, timer_value=5, pc_next=0x012 -> expire after 5 IDLE cycles.
//     trap=1 for one cycle, then saved_pc=0x012, cause=1, in_service=1.
//  3. halt_req and timer expiry on the same edge -> trap with cause=2, timer
//     stays pending. int_ack gives cause=0; int_return gives a second trap
//     with cause=1.
//  4. halt_req during SERVICE -> no trap while in_service.
//     After int_return: trap one cycle later, cause=2.
//  5. timer_value=0 then 100 idle cycles -> timer_running=0, trap never set.
//     Reload 3 on the expiry cycle -> no trap, expires 3 cycles later.
//  6. Timer armed with 4, trap taken on halt after 2 cycles -> counter frozen.
//     After int_return, the timer trap occurs after 2 more IDLE cycles.

Source files
------------

// File: rtl/interrupt_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler: the FSM state encoding and cause
// codes, also used by the control unit and the PC-select mux.
package interrupt_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRAP    = 2'd1,
      ST_SERVICE = 2'd2
   } sched_state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_TIMER = 2'd1;
   localparam logic [1:0] CAUSE_HALT  = 2'd2;

   function automatic logic [31:0] cause_word(input logic [1:0] code);
      return {30'b0, code};
   endfunction

endpackage

// File: rtl/interrupt_scheduler_quantum_timer.sv
// One-shot quantum counter: load/disarm on load_i, decrement while enabled,
// single-cycle expire pulse on the 1->0 step.
module quantum_timer #(
   parameter int TIMER_WIDTH = 16
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic                   count_enable_i,
   input  logic                   load_i,
   input  logic [TIMER_WIDTH-1:0] value_i,
   output logic                   expire_o,
   output logic                   running_o
);

   logic [TIMER_WIDTH-1:0] count_q, count_d;
   logic                   running_q, running_d;

   // A load on the expiry cycle wins, so no pulse is produced then.
   assign expire_o  = running_q & count_enable_i & ~load_i & (count_q == TIMER_WIDTH'(1));
   assign running_o = running_q;

   always_comb begin
      // NOTE: defaults first so every path assigns the next state and no latch is inferred.
      count_d   = count_q;
      running_d = running_q;
      if (load_i) begin
         if (value_i != '0) begin
            count_d   = value_i;
            running_d = 1'b1;
         end else begin
            running_d = 1'b0;
         end
      end else if (running_q && count_enable_i) begin
         count_d = count_q - TIMER_WIDTH'(1);
         if (count_q == TIMER_WIDTH'(1)) running_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all sequential state, so every register
         // samples the values from before the edge.
         count_q   <= count_d;
         running_q <= running_d;
      end
   end

endmodule

// File: rtl/interrupt_scheduler.sv
// Sequences halt and quantum-timer traps: pending flags, IDLE/TRAP/SERVICE FSM,
// saved PC and cause word for the handler.
module interrupt_scheduler
   import interrupt_scheduler_pkg::*;
#(
   parameter int                 PC_WIDTH    = 11,
   parameter int                 TIMER_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = '0
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic                   halt_req,
   input  logic                   timer_set,
   input  logic [TIMER_WIDTH-1:0] timer_value,
   input  logic [PC_WIDTH-1:0]    pc_next,
   input  logic                   int_ack,
   input  logic                   int_return,
   output logic                   trap,
   output logic [PC_WIDTH-1:0]    trap_vector,
   output logic [PC_WIDTH-1:0]    saved_pc,
   output logic [31:0]            cause,
   output logic                   in_service,
   output logic                   timer_running
);

   sched_state_e        state_q;
   logic                halt_pend_q;
   logic                timer_pend_q;
   logic [PC_WIDTH-1:0] saved_pc_q;
   logic [1:0]          cause_q;
   logic                timer_expire;

   quantum_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
      .Clock          (Clock),
      .Reset_n        (Reset_n),
      .count_enable_i (state_q == ST_IDLE),
      .load_i         (timer_set),
      .value_i        (timer_value),
      .expire_o       (timer_expire),
      .running_o      (timer_running)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         halt_pend_q  <= 1'b0;
         timer_pend_q <= 1'b0;
         saved_pc_q   <= '0;
         cause_q      <= CAUSE_NONE;
      end else begin
         if (halt_req)     halt_pend_q  <= 1'b1;
         if (timer_expire) timer_pend_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (halt_pend_q || timer_pend_q) state_q <= ST_TRAP;
            end
            ST_TRAP: begin
               state_q    <= ST_SERVICE;
               saved_pc_q <= pc_next;
               // Halt wins; a fresh halt_req on this edge re-arms its own flag.
               if (halt_pend_q) begin
                  cause_q     <= CAUSE_HALT;
                  halt_pend_q <= halt_req;
               end else begin
                  cause_q      <= CAUSE_TIMER;
                  timer_pend_q <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (int_ack)    cause_q <= CAUSE_NONE;
               if (int_return) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign trap        = (state_q == ST_TRAP);
   assign in_service  = (state_q == ST_SERVICE);
   assign trap_vector = TRAP_VECTOR;
   assign saved_pc    = saved_pc_q;
   assign cause       = cause_word(cause_q);

endmodule
